// File: rtl/seq_det_pkg.sv
// Shared types, width limits and sizing helper for the parametrised serial pattern detector.
package seq_det_pkg;

   typedef enum logic [0:0] {
      FILL  = 1'b0,
      ARMED = 1'b1
   } seq_det_state_t;

   localparam int MIN_PAT_WIDTH = 2;
   localparam int MAX_PAT_WIDTH = 16;

   // fill_cnt must count up to PAT_WIDTH-1, so never narrower than one bit.
   function automatic int fill_cnt_width(input int pat_width);
      int w;
      w = $clog2(pat_width);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/seq_det_history.sv
// History shift register of previously accepted bits (newest in bit 0), with sync clear and async reset.
module seq_det_history #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             shift_en_i,
   input  logic             clr_i,
   input  logic             bit_i,
   output logic [WIDTH-1:0] hist_o
);

   logic [WIDTH-1:0] hist_q;
   logic [WIDTH-1:0] hist_d;
   logic [WIDTH-1:0] shifted_s;

   generate
      if (WIDTH == 1) begin : g_single
         assign shifted_s = bit_i;
      end else begin : g_multi
         assign shifted_s = {hist_q[WIDTH-2:0], bit_i};
      end
   endgenerate

   // Clear wins over shift so a load or a non-overlapping match discards the bit just seen.
   always_comb begin
      if (clr_i) begin
         hist_d = {WIDTH{1'b0}};
      end else if (shift_en_i) begin
         hist_d = shifted_s;
      end else begin
         hist_d = hist_q;
      end
   end

   // History register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         hist_q <= {WIDTH{1'b0}};
      end else begin
         hist_q <= hist_d;
      end
   end

   assign hist_o = hist_q;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised Mealy serial pattern detector with run-time pattern load and overlap control.
// Optional saturating match counter enabled by defining SEQ_DET_COUNT_EN.
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int                   PAT_WIDTH     = 4,
   parameter int                   CNT_WIDTH     = 8,
   parameter logic [PAT_WIDTH-1:0] RESET_PATTERN = PAT_WIDTH'(4'b1101)
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 i,
   input  logic                 i_valid,
   input  logic [PAT_WIDTH-1:0] pattern,
   input  logic                 load_pattern,
   input  logic                 overlap_en,
   output logic                 o
`ifdef SEQ_DET_COUNT_EN
   ,
   output logic [CNT_WIDTH-1:0] match_count
`endif
);

   localparam int FCW = fill_cnt_width(PAT_WIDTH);
   localparam int HW  = PAT_WIDTH - 1;
   localparam logic [FCW-1:0] FILL_LAST = FCW'(PAT_WIDTH - 2);

   generate
      if (PAT_WIDTH < MIN_PAT_WIDTH || PAT_WIDTH > MAX_PAT_WIDTH || CNT_WIDTH < 1) begin : g_bad_params
         $error("seq_detector_param: illegal PAT_WIDTH or CNT_WIDTH");
      end
   endgenerate

   seq_det_state_t       state_q;
   logic [FCW-1:0]       fill_q;
   logic [PAT_WIDTH-1:0] pat_q;
   logic [HW-1:0]        hist_s;
   logic                 match_s;
   logic                 shift_en_s;
   logic                 clr_s;

   assign match_s    = (state_q == ARMED) && i_valid && ({hist_s, i} == pat_q);
   assign o          = match_s;
   assign shift_en_s = i_valid && !load_pattern;
   assign clr_s      = load_pattern || (match_s && !overlap_en);

   seq_det_history #(
      .WIDTH (HW)
   ) u_history (
      .clk        (clk),
      .n_rst      (n_rst),
      .shift_en_i (shift_en_s),
      .clr_i      (clr_s),
      .bit_i      (i),
      .hist_o     (hist_s)
   );

   // Fill/armed sequencing and pattern register; load has priority over the data bit.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= FILL;
         fill_q  <= {FCW{1'b0}};
         pat_q   <= RESET_PATTERN;
      end else if (load_pattern) begin
         state_q <= FILL;
         fill_q  <= {FCW{1'b0}};
         pat_q   <= pattern;
      end else if (i_valid) begin
         case (state_q)
            FILL: begin
               fill_q <= fill_q + FCW'(1);
               if (fill_q == FILL_LAST) begin
                  state_q <= ARMED;
               end else begin
                  state_q <= FILL;
               end
            end
            ARMED: begin
               if (match_s && !overlap_en) begin
                  state_q <= FILL;
                  fill_q  <= {FCW{1'b0}};
               end else begin
                  state_q <= ARMED;
               end
            end
            default: begin
               state_q <= FILL;
               fill_q  <= {FCW{1'b0}};
            end
         endcase
      end else begin
         state_q <= state_q;
      end
   end

`ifdef SEQ_DET_COUNT_EN
   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] cnt_d;

   // Saturating count of match pulses; survives pattern loads.
   always_comb begin
      if (match_s && (cnt_q != {CNT_WIDTH{1'b1}})) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Match counter register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt_q <= {CNT_WIDTH{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign match_count = cnt_q;
`endif

endmodule
